// File: rtl/hard_mem_1rw_arb_ctrl_pkg.sv
// Shared types for the two-client 1rw SRAM controller: FSM state and client count.
package hard_mem_1rw_arb_ctrl_pkg;

   localparam int num_clients_lp = 2;

   typedef enum logic [0:0] {
      e_clear = 1'b0,
      e_run   = 1'b1
   } state_e;

endpackage

// File: rtl/hard_mem_1rw_rr_arb.sv
// Two-way round-robin arbiter; the last-granted client loses a tie.
module hard_mem_1rw_rr_arb
   import hard_mem_1rw_arb_ctrl_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      en_i,
   input  logic [num_clients_lp-1:0] elig_i,
   output logic [num_clients_lp-1:0] grant_o
);

   logic                      r_last_gnt;
   logic [num_clients_lp-1:0] w_grant;

   always_comb begin
      w_grant = '0;
      if (en_i) begin
         if (&elig_i) begin
            w_grant = r_last_gnt ? 2'b01 : 2'b10;
         end else begin
            w_grant = elig_i;
         end
      end
   end

   // Starts at client 1 so that client 0 wins the first tie.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_last_gnt <= 1'b1;
      end else if (|w_grant) begin
         r_last_gnt <= w_grant[1];
      end
   end

   assign grant_o = w_grant;

endmodule

// File: rtl/hard_mem_1rw_arb_ctrl.sv
// Zero-fills a single-port SRAM, then arbitrates two clients onto it with
// registered per-client read response slots.
module hard_mem_1rw_arb_ctrl
   import hard_mem_1rw_arb_ctrl_pkg::*;
#(
   parameter  int width_p       = 64,
   parameter  int els_p         = 512,
   localparam int addr_width_lp = $clog2(els_p)
)(
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic                                  clear_i,
   output logic                                  init_done_o,
   input  logic [num_clients_lp-1:0]             req_v_i,
   input  logic [num_clients_lp-1:0]             req_w_i,
   input  logic [num_clients_lp*addr_width_lp-1:0] req_addr_i,
   input  logic [num_clients_lp*width_p-1:0]     req_data_i,
   output logic [num_clients_lp-1:0]             req_ready_o,
   output logic [num_clients_lp-1:0]             resp_v_o,
   output logic [num_clients_lp*width_p-1:0]     resp_data_o,
   input  logic [num_clients_lp-1:0]             resp_yumi_i,
   output logic                                  mem_v_o,
   output logic                                  mem_w_o,
   output logic [addr_width_lp-1:0]              mem_addr_o,
   output logic [width_p-1:0]                    mem_data_o,
   input  logic [width_p-1:0]                    mem_data_i
);

   localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

   state_e                    r_state;
   logic [addr_width_lp-1:0]  r_clear_cnt;
   logic [num_clients_lp-1:0] w_inflight;
   logic [num_clients_lp-1:0] w_elig;
   logic [num_clients_lp-1:0] w_grant;
   logic                      w_arb_en;
   logic                      w_gnt_idx;

   assign w_arb_en    = (r_state == e_run) && !clear_i;
   assign init_done_o = (r_state == e_run);
   assign req_ready_o = w_grant;
   assign w_gnt_idx   = w_grant[1];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= e_clear;
         r_clear_cnt <= '0;
      end else begin
         case (r_state)
            e_clear: begin
               if (r_clear_cnt == last_addr_lp) begin
                  r_state     <= e_run;
                  r_clear_cnt <= '0;
               end else begin
                  r_clear_cnt <= r_clear_cnt + 1'b1;
               end
            end
            e_run: begin
               if (clear_i) begin
                  r_state     <= e_clear;
                  r_clear_cnt <= '0;
               end
            end
            default: begin
               r_state     <= e_clear;
               r_clear_cnt <= '0;
            end
         endcase
      end
   end

   // Slots capture wrapper data the cycle after issue, independent of FSM
   // state, so a clear never discards an outstanding or held read.
   for (genvar gi = 0; gi < num_clients_lp; gi++) begin : g_client
      logic               r_inflight;
      logic               r_slot_v;
      logic [width_p-1:0] r_slot_data;

      assign w_elig[gi] = req_v_i[gi] &
                          (req_w_i[gi] | (~r_inflight & (~r_slot_v | resp_yumi_i[gi])));

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            r_inflight  <= 1'b0;
            r_slot_v    <= 1'b0;
            r_slot_data <= '0;
         end else begin
            r_inflight <= w_grant[gi] & ~req_w_i[gi];
            if (r_inflight) begin
               r_slot_v    <= 1'b1;
               r_slot_data <= mem_data_i;
            end else if (resp_yumi_i[gi]) begin
               r_slot_v <= 1'b0;
            end
         end
      end

      assign w_inflight[gi]                      = r_inflight;
      assign resp_v_o[gi]                        = r_slot_v;
      assign resp_data_o[gi*width_p +: width_p]  = r_slot_data;
   end

   hard_mem_1rw_rr_arb u_arb (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (w_arb_en),
      .elig_i    (w_elig),
      .grant_o   (w_grant)
   );

   always_comb begin
      mem_v_o    = 1'b0;
      mem_w_o    = 1'b0;
      mem_addr_o = '0;
      mem_data_o = '0;
      if (r_state == e_clear) begin
         mem_v_o    = 1'b1;
         mem_w_o    = 1'b1;
         mem_addr_o = r_clear_cnt;
      end else if (|w_grant) begin
         mem_v_o    = 1'b1;
         mem_w_o    = req_w_i[w_gnt_idx];
         mem_addr_o = req_addr_i[w_gnt_idx*addr_width_lp +: addr_width_lp];
         mem_data_o = req_data_i[w_gnt_idx*width_p +: width_p];
      end
   end

endmodule

// File: tb/tb_hard_mem_1rw_arb_ctrl.sv
// Bench for hard_mem_1rw_arb_ctrl: SRAM stand-in, transaction-level model, directed and random traffic.
module tb_hard_mem_1rw_arb_ctrl;

   localparam int W  = 64;
   localparam int E  = 512;
   localparam int AW = 9;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          clear_i;
   logic          init_done_o;
   logic [1:0]    req_v_i, req_w_i;
   logic [2*AW-1:0] req_addr_i;
   logic [2*W-1:0]  req_data_i;
   logic [1:0]    req_ready_o, resp_v_o, resp_yumi_i;
   logic [2*W-1:0]  resp_data_o;
   logic          mem_v_o, mem_w_o;
   logic [AW-1:0] mem_addr_o;
   logic [W-1:0]  mem_data_o, mem_data_i;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   hard_mem_1rw_arb_ctrl #(.width_p(W), .els_p(E)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_i), .init_done_o(init_done_o),
      .req_v_i(req_v_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
      .resp_yumi_i(resp_yumi_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
   );

   // SRAM stand-in: synchronous write, registered read.
   logic [W-1:0] sram [E];
   logic [W-1:0] sram_q;
   always @(posedge clk_i) begin
      if (mem_v_o) begin
         if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
         else         sram_q <= sram[mem_addr_o];
      end
   end
   assign mem_data_i = sram_q;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: golden memory contents, clear progress, and at most one
   // owed read per client with the cycle its data must appear.
   bit [W-1:0] gold [E];
   bit         m_clear;
   int         m_cnt;
   bit         m_last;
   bit         m_owed [2];
   int         m_at   [2];
   bit [W-1:0] m_dat  [2];
   int         cyc;

   always @(negedge clk_i) begin : model
      logic [1:0]    exp_rv, elig, g;
      logic          exp_mv, exp_mw;
      logic [AW-1:0] exp_ma;
      logic [W-1:0]  exp_md;
      int            idx;
      if (!reset_n_i) begin
         m_clear = 1'b1; m_cnt = 0; m_last = 1'b1; cyc = 0;
         m_owed[0] = 1'b0; m_owed[1] = 1'b0;
      end else begin
         for (int r = 0; r < 2; r++) exp_rv[r] = m_owed[r] && (cyc >= m_at[r]);
         check("resp_v", 64'(resp_v_o), 64'(exp_rv));
         for (int r = 0; r < 2; r++)
            if (exp_rv[r]) check($sformatf("resp_data%0d", r), resp_data_o[r*W +: W], m_dat[r]);
         check("init_done", 64'(init_done_o), 64'(!m_clear));

         g = 2'b00;
         if (!m_clear && !clear_i) begin
            for (int r = 0; r < 2; r++)
               elig[r] = req_v_i[r] && (req_w_i[r] || !m_owed[r] || (exp_rv[r] && resp_yumi_i[r]));
            if (elig == 2'b11) g = m_last ? 2'b01 : 2'b10;
            else               g = elig;
         end
         check("ready", 64'(req_ready_o), 64'(g));

         idx = g[1] ? 1 : 0;
         exp_mv = 1'b0; exp_mw = 1'b0; exp_ma = '0; exp_md = '0;
         if (m_clear) begin
            exp_mv = 1'b1; exp_mw = 1'b1; exp_ma = AW'(m_cnt);
         end else if (g != 2'b00) begin
            exp_mv = 1'b1;
            exp_mw = req_w_i[idx];
            exp_ma = req_addr_i[idx*AW +: AW];
            exp_md = req_data_i[idx*W +: W];
         end
         check("mem_v", 64'(mem_v_o), 64'(exp_mv));
         check("mem_w", 64'(mem_w_o), 64'(exp_mw));
         check("mem_addr", 64'(mem_addr_o), 64'(exp_ma));
         check("mem_data", mem_data_o, exp_md);

         for (int r = 0; r < 2; r++) if (exp_rv[r] && resp_yumi_i[r]) m_owed[r] = 1'b0;
         if (m_clear) begin
            gold[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == E) m_clear = 1'b0;
         end else if (clear_i) begin
            m_clear = 1'b1; m_cnt = 0;
         end else if (g != 2'b00) begin
            m_last = (idx == 1);
            if (exp_mw) begin
               gold[exp_ma] = exp_md;
            end else begin
               m_owed[idx] = 1'b1;
               m_at[idx]   = cyc + 2;
               m_dat[idx]  = gold[exp_ma];
            end
         end
         cyc++;
      end
   end

   task automatic idle();
      req_v_i = '0; req_w_i = '0; req_addr_i = '0; req_data_i = '0;
      resp_yumi_i = '0; clear_i = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_i); #1;
   endtask

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (init_done_o !== 1'b1 && n < 600) begin step(); n++; end
      check(name, 64'(n), 64'(E));
      $display("clear sequence %s finished after %0d cycles", name, n);
   endtask

   logic [1:0] alt_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int n;
      idle();
      reset_n_i = 1'b0;
      #1;
      check("rst_init_done", 64'(init_done_o), 64'd0);
      check("rst_ready",     64'(req_ready_o), 64'd0);
      check("rst_resp_v",    64'(resp_v_o),    64'd0);
      check("rst_resp_data", resp_data_o[63:0] | resp_data_o[127:64], 64'd0);
      check("rst_mem_v",     64'(mem_v_o),     64'd1);
      check("rst_mem_addr",  64'(mem_addr_o),  64'd0);
      repeat (3) step();
      reset_n_i = 1'b1;
      wait_init("clear_cycles");

      // Write then read-back across clients.
      req_v_i = 2'b01; req_w_i = 2'b01; req_addr_i[AW-1:0] = 9'd5; req_data_i[63:0] = 64'hDEADBEEF;
      #1 check("dir_wr_grant", 64'(req_ready_o), 64'd1);
      $display("txn c0 write addr 5 data deadbeef");
      step();
      idle(); req_v_i = 2'b10; req_addr_i[2*AW-1:AW] = 9'd5;
      #1 check("dir_rd_grant", 64'(req_ready_o), 64'd2);
      $display("txn c1 read addr 5");
      step(); idle(); step();
      check("dir_rd_v", 64'(resp_v_o[1]), 64'd1);
      check("dir_rd_data", resp_data_o[127:64], 64'hDEADBEEF);
      $display("txn c1 response %h", resp_data_o[127:64]);
      resp_yumi_i = 2'b10; step(); idle();

      // Both clients writing continuously alternate, starting with client 0.
      for (int k = 0; k < 4; k++) begin
         req_v_i = 2'b11; req_w_i = 2'b11;
         req_addr_i = {9'(20 + k), 9'(30 + k)};
         req_data_i = {32'h0, $urandom, 32'h0, $urandom};
         #1 check($sformatf("alt_grant%0d", k), 64'(req_ready_o), 64'(alt_exp[k]));
         $display("txn alternate write %0d grant %b", k, req_ready_o);
         step();
      end
      idle();

      // Unconsumed response blocks further client-0 reads only.
      req_v_i = 2'b01; req_addr_i[AW-1:0] = 9'd5;
      #1 check("blk_first", 64'(req_ready_o), 64'd1);
      step();
      for (int k = 0; k < 4; k++) begin
         req_v_i = 2'b11; req_w_i = 2'b10; req_addr_i = {9'(40 + k), 9'd6};
         req_data_i[127:64] = 64'(k);
         #1 check($sformatf("blk_c1_%0d", k), 64'(req_ready_o), 64'd2);
         $display("txn blocked c0 read, c1 write grant %b", req_ready_o);
         step();
      end
      req_v_i = 2'b01; req_w_i = 2'b00; resp_yumi_i = 2'b01;
      #1 check("yumi_resume", 64'(req_ready_o), 64'd1);
      step(); idle(); step(); step();
      resp_yumi_i = 2'b01; step(); idle();

      // Clear with a read in flight: the read still completes, then zero-fill.
      req_v_i = 2'b01; req_w_i = 2'b00; req_addr_i[AW-1:0] = 9'd5;
      step();
      idle(); clear_i = 1'b1;
      #1 check("clear_no_grant", 64'(req_ready_o), 64'd0);
      step(); idle();
      check("clear_rd_kept", 64'(resp_v_o[0]), 64'd1);
      check("clear_started", 64'(init_done_o), 64'd0);
      $display("txn c0 read survived clear, data %h", resp_data_o[63:0]);
      resp_yumi_i = 2'b01; step(); idle();
      n = 0;
      while (init_done_o !== 1'b1 && n < 600) begin step(); n++; end
      check("clear2_done", 64'(init_done_o), 64'd1);
      req_v_i = 2'b10; req_addr_i[2*AW-1:AW] = 9'd5;
      step(); idle(); step();
      check("post_clear_v", 64'(resp_v_o[1]), 64'd1);
      check("post_clear_data", resp_data_o[127:64], 64'd0);
      $display("txn c1 read addr 5 after clear data %h", resp_data_o[127:64]);
      resp_yumi_i = 2'b10; step(); idle();

      // Randomized traffic checked cycle by cycle against the model.
      for (int k = 0; k < 3000; k++) begin
         req_v_i     = 2'($urandom);
         req_w_i     = 2'($urandom);
         req_addr_i  = {9'($urandom_range(0, 15)), 9'($urandom_range(0, 15))};
         req_data_i  = {$urandom, $urandom, $urandom, $urandom};
         resp_yumi_i = resp_v_o & 2'($urandom);
         clear_i     = ($urandom_range(0, 299) == 0);
         #1;
         if (req_ready_o != 2'b00)
            $display("txn rnd %0d grant %b w %b addr %h", k, req_ready_o, mem_w_o, mem_addr_o);
         step();
      end
      idle();
      n = 0;
      while (init_done_o !== 1'b1 && n < 600) begin step(); n++; end

      // Reset asserted mid-clear with a response held.
      req_v_i = 2'b01; req_w_i = 2'b00; req_addr_i[AW-1:0] = 9'd3;
      step(); idle(); step(); step();
      clear_i = 1'b1; step(); idle();
      n = 0;
      while (mem_addr_o !== 9'd100 && n < 600) begin step(); n++; end
      check("reach_addr100", 64'(mem_addr_o), 64'd100);
      check("held_before_rst", 64'(resp_v_o[0]), 64'd1);
      #2 reset_n_i = 1'b0;
      #1;
      check("mid_rst_init_done", 64'(init_done_o), 64'd0);
      check("mid_rst_resp_v",    64'(resp_v_o),    64'd0);
      check("mid_rst_resp_data", resp_data_o[63:0] | resp_data_o[127:64], 64'd0);
      check("mid_rst_mem_addr",  64'(mem_addr_o),  64'd0);
      check("mid_rst_mem_vw",    64'({mem_v_o, mem_w_o}), 64'd3);
      $display("txn reset asserted at clear address 100");
      step(); step();
      reset_n_i = 1'b1;
      check("restart_addr", 64'(mem_addr_o), 64'd0);
      wait_init("clear_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
